// File: rtl/flags_branch_ctrl_if.sv
// Bus between the pipeline and the flags/branch controller: EX flag-setter,
// decode branch request, flush, and the resolved branch/stall outputs.
interface flags_branch_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ex_valid;
    logic             ex_set_flags;
    logic [63:0]      ex_result;
    logic             ex_carry;
    logic             ex_overflow;
    logic             dec_valid;
    logic             dec_bcond;
    logic [3:0]       dec_cond;
    logic             dec_cbz;
    logic             dec_cbnz;
    logic [63:0]      dec_reg;
    logic             flush;
    logic [3:0]       flags;
    logic             stall;
    logic             br_valid;
    logic             br_taken;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output ex_valid, ex_set_flags, ex_result, ex_carry, ex_overflow,
        output dec_valid, dec_bcond, dec_cond, dec_cbz, dec_cbnz, dec_reg, flush,
        input  flags, stall, br_valid, br_taken, stall_count
    );

    modport slave (
        input  ex_valid, ex_set_flags, ex_result, ex_carry, ex_overflow,
        input  dec_valid, dec_bcond, dec_cond, dec_cbz, dec_cbnz, dec_reg, flush,
        output flags, stall, br_valid, br_taken, stall_count
    );
endinterface

// File: rtl/flags_branch_ctrl.sv
// NZCV flags register, decode-stage branch resolution (B.cond/CBZ/CBNZ) and
// flags RAW hazard handling by either EX forwarding or a one-cycle stall.
module flags_branch_ctrl #(
    parameter bit FORWARD = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    flags_branch_ctrl_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic       set_flags;
    logic       hazard;
    logic       ex_zero;
    logic       dec_zero;
    logic [3:0] ex_flags;
    logic       stall_c;
    logic       br_valid_c;
    logic       br_taken_c;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !c | z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = z | (n != v);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    always_comb begin
        ex_zero   = (bus.ex_result == 64'd0);
        dec_zero  = (bus.dec_reg == 64'd0);
        ex_flags  = {bus.ex_result[63], ex_zero, bus.ex_carry, bus.ex_overflow};
        set_flags = bus.ex_valid & bus.ex_set_flags;
        hazard    = bus.dec_valid & bus.dec_bcond & set_flags;
        // Flag writes are independent of flush and of the stall FSM.
        flags_d   = set_flags ? ex_flags : flags_q;

        state_d    = IDLE;
        stall_c    = 1'b0;
        br_valid_c = 1'b0;
        br_taken_c = 1'b0;

        if (bus.flush) begin
            state_d = IDLE;
        end else if (state_q == WAIT) begin
            // EX holds the injected bubble, so registered flags are current.
            br_valid_c = bus.dec_valid & bus.dec_bcond;
            br_taken_c = br_valid_c & cond_eval(bus.dec_cond, flags_q);
        end else if (bus.dec_bcond) begin
            if (hazard && !FORWARD) begin
                stall_c = 1'b1;
                state_d = WAIT;
            end else begin
                br_valid_c = bus.dec_valid;
                br_taken_c = bus.dec_valid &
                             cond_eval(bus.dec_cond, hazard ? ex_flags : flags_q);
            end
        end else if (bus.dec_cbz) begin
            br_valid_c = bus.dec_valid;
            br_taken_c = bus.dec_valid & dec_zero;
        end else if (bus.dec_cbnz) begin
            br_valid_c = bus.dec_valid;
            br_taken_c = bus.dec_valid & !dec_zero;
        end

        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            flags_q       <= 4'b0000;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flags_q       <= flags_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Gate with reset so a held B.cond cannot resolve while reset is asserted.
    assign bus.flags       = flags_q;
    assign bus.stall       = stall_c & ~reset;
    assign bus.br_valid    = br_valid_c & ~reset;
    assign bus.br_taken    = br_taken_c & ~reset;
    assign bus.stall_count = stall_count_q;
endmodule

// File: tb/tb_flags_branch_ctrl.sv
// Directed bench: u0 stalls (FORWARD=0), u1 forwards (FORWARD=1),
// u2 stalls with a 2-bit counter; all three see the same stimulus.
module tb_flags_branch_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid, ex_set_flags, ex_carry, ex_overflow;
    logic        dec_valid, dec_bcond, dec_cbz, dec_cbnz, flush;
    logic [63:0] ex_result, dec_reg;
    logic [3:0]  dec_cond;
    logic [15:0] tbl;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          sc0 = 0;

    always #5 clk = ~clk;

    flags_branch_ctrl_if #(.CNT_W(16)) b0 ();
    flags_branch_ctrl_if #(.CNT_W(16)) b1 ();
    flags_branch_ctrl_if #(.CNT_W(2))  b2 ();

    assign b0.ex_valid = ex_valid;   assign b1.ex_valid = ex_valid;   assign b2.ex_valid = ex_valid;
    assign b0.ex_set_flags = ex_set_flags; assign b1.ex_set_flags = ex_set_flags; assign b2.ex_set_flags = ex_set_flags;
    assign b0.ex_result = ex_result; assign b1.ex_result = ex_result; assign b2.ex_result = ex_result;
    assign b0.ex_carry = ex_carry;   assign b1.ex_carry = ex_carry;   assign b2.ex_carry = ex_carry;
    assign b0.ex_overflow = ex_overflow; assign b1.ex_overflow = ex_overflow; assign b2.ex_overflow = ex_overflow;
    assign b0.dec_valid = dec_valid; assign b1.dec_valid = dec_valid; assign b2.dec_valid = dec_valid;
    assign b0.dec_bcond = dec_bcond; assign b1.dec_bcond = dec_bcond; assign b2.dec_bcond = dec_bcond;
    assign b0.dec_cond = dec_cond;   assign b1.dec_cond = dec_cond;   assign b2.dec_cond = dec_cond;
    assign b0.dec_cbz = dec_cbz;     assign b1.dec_cbz = dec_cbz;     assign b2.dec_cbz = dec_cbz;
    assign b0.dec_cbnz = dec_cbnz;   assign b1.dec_cbnz = dec_cbnz;   assign b2.dec_cbnz = dec_cbnz;
    assign b0.dec_reg = dec_reg;     assign b1.dec_reg = dec_reg;     assign b2.dec_reg = dec_reg;
    assign b0.flush = flush;         assign b1.flush = flush;         assign b2.flush = flush;

    flags_branch_ctrl #(.FORWARD(1'b0), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(b0));
    flags_branch_ctrl #(.FORWARD(1'b1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
    flags_branch_ctrl #(.FORWARD(1'b0), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(b2));

    task automatic idle_in();
        ex_valid = 0; ex_set_flags = 0; ex_result = '0; ex_carry = 0; ex_overflow = 0;
        dec_valid = 0; dec_bcond = 0; dec_cond = 4'h0; dec_cbz = 0; dec_cbnz = 0;
        dec_reg = '0; flush = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ex(input logic [63:0] r, input logic c, input logic v);
        ex_valid = 1; ex_set_flags = 1; ex_result = r; ex_carry = c; ex_overflow = v;
    endtask

    task automatic ex_off();
        ex_valid = 0; ex_set_flags = 0;
    endtask

    task automatic set_bcond(input logic [3:0] c);
        dec_valid = 1; dec_bcond = 1; dec_cond = c; dec_cbz = 0; dec_cbnz = 0;
    endtask

    task automatic test_reset();
        idle_in();
        reset = 1;
        #3;
        n_cmp++; if (b0.flags !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got %b want 0000", b0.flags); end
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got %b want 0", b0.stall); end
        n_cmp++; if (b0.br_valid !== 1'b0) begin n_bad++; $display("FAIL rst_br_valid got %b want 0", b0.br_valid); end
        n_cmp++; if (b0.stall_count !== 16'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", b0.stall_count); end
        #7 reset = 0;
        step();
    endtask

    task automatic test_flags_update();
        set_ex(64'h0, 1'b1, 1'b0);
        #2;
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL fu_nostall got %b want 0", b0.stall); end
        step();
        idle_in();
        #2;
        n_cmp++; if (b0.flags !== 4'b0110) begin n_bad++; $display("FAIL fu_flags0 got %b want 0110", b0.flags); end
        n_cmp++; if (b1.flags !== 4'b0110) begin n_bad++; $display("FAIL fu_flags1 got %b want 0110", b1.flags); end
        set_bcond(4'h0);
        #2;
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL beq_valid got %b want 1", b0.br_valid); end
        n_cmp++; if (b0.br_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken got %b want 1", b0.br_taken); end
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL beq_stall got %b want 0", b0.stall); end
        n_cmp++; if (b1.br_taken !== 1'b1) begin n_bad++; $display("FAIL beq_taken1 got %b want 1", b1.br_taken); end
        idle_in();
        step();
    endtask

    task automatic test_hazard();
        set_ex(64'h8000000000000000, 1'b0, 1'b0);
        set_bcond(4'h4);
        #2;
        n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL hz_stall0 got %b want 1", b0.stall); end
        n_cmp++; if (b0.br_valid !== 1'b0) begin n_bad++; $display("FAIL hz_valid0 got %b want 0", b0.br_valid); end
        n_cmp++; if (b1.stall !== 1'b0) begin n_bad++; $display("FAIL fw_stall got %b want 0", b1.stall); end
        n_cmp++; if (b1.br_valid !== 1'b1) begin n_bad++; $display("FAIL fw_valid got %b want 1", b1.br_valid); end
        n_cmp++; if (b1.br_taken !== 1'b1) begin n_bad++; $display("FAIL fw_taken got %b want 1", b1.br_taken); end
        step();
        sc0++;
        ex_off();
        #2;
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL hz_wait_stall got %b want 0", b0.stall); end
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL hz_wait_valid got %b want 1", b0.br_valid); end
        n_cmp++; if (b0.br_taken !== 1'b1) begin n_bad++; $display("FAIL hz_wait_taken got %b want 1", b0.br_taken); end
        n_cmp++; if (b0.flags !== 4'b1000) begin n_bad++; $display("FAIL hz_flags got %b want 1000", b0.flags); end
        n_cmp++; if (b0.stall_count !== 16'(sc0)) begin n_bad++; $display("FAIL hz_count got %0d want %0d", b0.stall_count, sc0); end
        n_cmp++; if (b1.stall_count !== 16'd0) begin n_bad++; $display("FAIL fw_count got %0d want 0", b1.stall_count); end
        n_cmp++; if (b2.stall_count !== 2'd1) begin n_bad++; $display("FAIL hz_count2 got %0d want 1", b2.stall_count); end
        idle_in();
        step();
    endtask

    task automatic test_conds();
        // flags = 1000 (N only)
        tbl = 16'hEA9A;
        for (int i = 0; i < 16; i++) begin
            set_bcond(4'(i));
            #1;
            n_cmp++; if (b0.br_taken !== tbl[i]) begin n_bad++; $display("FAIL cond_n cond=%0h got %b want %b", i, b0.br_taken, tbl[i]); end
        end
        idle_in();
        set_ex(64'h0, 1'b0, 1'b1);
        step();
        idle_in();
        // flags = 0101 (Z and V)
        tbl = 16'hEA69;
        for (int i = 0; i < 16; i++) begin
            set_bcond(4'(i));
            #1;
            n_cmp++; if (b0.br_taken !== tbl[i]) begin n_bad++; $display("FAIL cond_zv cond=%0h got %b want %b", i, b0.br_taken, tbl[i]); end
        end
        idle_in();
        step();
    endtask

    task automatic test_cbz();
        // bcond outranks cbz: NE with Z=1 is not taken, CBZ would be
        dec_valid = 1; dec_bcond = 1; dec_cond = 4'h1; dec_cbz = 1; dec_reg = 64'd0;
        #2;
        n_cmp++; if (b0.br_taken !== 1'b0) begin n_bad++; $display("FAIL prio_taken got %b want 0", b0.br_taken); end
        idle_in();
        set_ex(64'd5, 1'b0, 1'b0);
        dec_valid = 1; dec_cbz = 1; dec_reg = 64'd10;
        #2;
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL cbz10_valid got %b want 1", b0.br_valid); end
        n_cmp++; if (b0.br_taken !== 1'b0) begin n_bad++; $display("FAIL cbz10_taken got %b want 0", b0.br_taken); end
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL cbz10_stall got %b want 0", b0.stall); end
        dec_cbz = 0; dec_cbnz = 1;
        #2;
        n_cmp++; if (b0.br_taken !== 1'b1) begin n_bad++; $display("FAIL cbnz10_taken got %b want 1", b0.br_taken); end
        n_cmp++; if (b1.br_taken !== 1'b1) begin n_bad++; $display("FAIL cbnz10_taken1 got %b want 1", b1.br_taken); end
        dec_cbnz = 0; dec_cbz = 1; dec_reg = 64'd0;
        #2;
        n_cmp++; if (b0.br_taken !== 1'b1) begin n_bad++; $display("FAIL cbz0_taken got %b want 1", b0.br_taken); end
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL cbz0_stall got %b want 0", b0.stall); end
        idle_in();
        step();
    endtask

    task automatic test_flush();
        set_ex(64'd1, 1'b1, 1'b0);
        set_bcond(4'h0);
        flush = 1;
        #2;
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL fl_stall got %b want 0", b0.stall); end
        n_cmp++; if (b0.br_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid got %b want 0", b0.br_valid); end
        n_cmp++; if (b1.br_valid !== 1'b0) begin n_bad++; $display("FAIL fl_valid1 got %b want 0", b1.br_valid); end
        step();
        idle_in();
        dec_valid = 1; dec_cbz = 1; dec_reg = 64'd0;
        #2;
        n_cmp++; if (b0.flags !== 4'b0010) begin n_bad++; $display("FAIL fl_flags got %b want 0010", b0.flags); end
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL fl_idle got %b want 1", b0.br_valid); end
        n_cmp++; if (b0.stall_count !== 16'(sc0)) begin n_bad++; $display("FAIL fl_count got %0d want %0d", b0.stall_count, sc0); end
        idle_in();
        set_ex(64'd0, 1'b0, 1'b0);
        set_bcond(4'h1);
        #2;
        n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL flw_stall got %b want 1", b0.stall); end
        step();
        sc0++;
        ex_off();
        flush = 1;
        #2;
        n_cmp++; if (b0.br_valid !== 1'b0) begin n_bad++; $display("FAIL flw_valid got %b want 0", b0.br_valid); end
        step();
        idle_in();
        dec_valid = 1; dec_cbz = 1; dec_reg = 64'd0;
        #2;
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL flw_idle got %b want 1", b0.br_valid); end
        idle_in();
        step();
    endtask

    task automatic test_back_to_back();
        set_ex(64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0);
        set_bcond(4'hB);
        #2;
        n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_a_stall got %b want 1", b0.stall); end
        step();
        sc0++;
        ex_off();
        #2;
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL b2b_b_stall got %b want 0", b0.stall); end
        n_cmp++; if (b0.br_taken !== 1'b1) begin n_bad++; $display("FAIL b2b_b_taken got %b want 1", b0.br_taken); end
        step();
        set_ex(64'd7, 1'b0, 1'b1);
        set_bcond(4'hC);
        #2;
        n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL b2b_c_stall got %b want 1", b0.stall); end
        step();
        sc0++;
        ex_off();
        #2;
        n_cmp++; if (b0.br_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_d_valid got %b want 1", b0.br_valid); end
        n_cmp++; if (b0.br_taken !== 1'b0) begin n_bad++; $display("FAIL b2b_d_taken got %b want 0", b0.br_taken); end
        n_cmp++; if (b0.stall_count !== 16'(sc0)) begin n_bad++; $display("FAIL b2b_count got %0d want %0d", b0.stall_count, sc0); end
        n_cmp++; if (b2.stall_count !== 2'(sc0 > 3 ? 3 : sc0)) begin n_bad++; $display("FAIL b2b_count2 got %0d want sat", b2.stall_count); end
        idle_in();
        step();
    endtask

    task automatic test_async_reset();
        set_ex(64'd0, 1'b0, 1'b0);
        set_bcond(4'h0);
        #2;
        n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL ar_stall got %b want 1", b0.stall); end
        step();
        ex_off();
        #2 reset = 1;
        sc0 = 0;
        #1;
        n_cmp++; if (b0.flags !== 4'b0000) begin n_bad++; $display("FAIL ar_flags got %b want 0000", b0.flags); end
        n_cmp++; if (b0.stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall2 got %b want 0", b0.stall); end
        n_cmp++; if (b0.br_valid !== 1'b0) begin n_bad++; $display("FAIL ar_valid got %b want 0", b0.br_valid); end
        n_cmp++; if (b0.stall_count !== 16'd0) begin n_bad++; $display("FAIL ar_count got %0d want 0", b0.stall_count); end
        n_cmp++; if (b2.stall_count !== 2'd0) begin n_bad++; $display("FAIL ar_count2 got %0d want 0", b2.stall_count); end
        #2 reset = 0;
        idle_in();
        step();
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) begin
            set_ex(64'd1, 1'b0, 1'b0);
            set_bcond(4'h0);
            #1;
            n_cmp++; if (b0.stall !== 1'b1) begin n_bad++; $display("FAIL sat_stall k=%0d got %b want 1", k, b0.stall); end
            step();
            sc0++;
            ex_off();
            step();
        end
        idle_in();
        #1;
        n_cmp++; if (b0.stall_count !== 16'(sc0)) begin n_bad++; $display("FAIL sat_count0 got %0d want %0d", b0.stall_count, sc0); end
        n_cmp++; if (b2.stall_count !== 2'd3) begin n_bad++; $display("FAIL sat_count2 got %0d want 3", b2.stall_count); end
        n_cmp++; if (b1.stall_count !== 16'd0) begin n_bad++; $display("FAIL sat_count1 got %0d want 0", b1.stall_count); end
    endtask

    initial begin
        test_reset();
        test_flags_update();
        test_hazard();
        test_conds();
        test_cbz();
        test_flush();
        test_back_to_back();
        test_async_reset();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
